// File: rtl/uart_text_writer_pkg.sv
// Shared text-mode constants and FSM state type for uart_text_writer and char_gen.
// Screen geometry defaults match the 640x480 mode with an 8x16 font.
package text_pkg;

    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int TEXT_ADDR_W = 12;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } wr_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/uart_text_writer_if.sv
// Byte input from uart_rx and text RAM write/cursor status toward char_gen.
// master drives received bytes; slave is the writer that produces RAM writes.
interface uart_text_writer_if #(
    parameter int ADDR_W = 12,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
);
    logic [7:0]        data;
    logic              data_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;
    logic              overflow;

    modport master (
        output data, data_ready,
        input  wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overflow
    );

    modport slave (
        input  data, data_ready,
        output wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy, overflow
    );
endinterface

// File: rtl/uart_text_writer_byte_fifo.sv
// Synchronous FIFO, DEPTH a power of 2; head visible the cycle after the first push.
// A push while full is accepted only together with a pop; otherwise it is ignored.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_text_writer.sv
// Turns uart_rx bytes into text RAM writes with a cursor; write appears 2 cycles after data_ready.
// Bytes queue in a small FIFO during screen clear; overflow is sticky. UART_TEXT_TAB_EN enables TAB.
module uart_text_writer
    import text_pkg::*;
#(
    parameter int COLS       = TEXT_COLS,
    parameter int ROWS       = TEXT_ROWS,
    parameter int ADDR_W     = TEXT_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_text_writer_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ovf_q, ovf_d;

    logic              pop;
    logic [7:0]        head;
    logic              fifo_full, fifo_empty;
    logic [ROW_W-1:0]  row_next;
`ifdef UART_TEXT_TAB_EN
    logic [COL_W:0]    tab_col;
`endif

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (bus.data_ready),
        .data_i  (bus.data),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
`ifdef UART_TEXT_TAB_EN
        tab_col   = ({1'b0, col_q} | (COL_W+1)'(7)) + (COL_W+1)'(1);
`endif
        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = CH_SPACE;
                if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
                else                        clr_cnt_d = clr_cnt_q + 1'b1;
            end
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head)
                        CH_CR: col_d = '0;
                        CH_LF: row_d = row_next;
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d     = col_q - 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = lin_addr(row_q, col_q - 1'b1);
                                wr_data_d = CH_SPACE;
                            end
                        end
                        CH_FF: begin
                            col_d     = '0;
                            row_d     = '0;
                            clr_cnt_d = '0;
                            state_d   = CLEAR;
                        end
`ifdef UART_TEXT_TAB_EN
                        CH_TAB: begin
                            if (tab_col >= (COL_W+1)'(COLS)) begin
                                col_d = '0;
                                row_d = row_next;
                            end else begin
                                col_d = tab_col[COL_W-1:0];
                            end
                        end
`endif
                        default: begin
                            if (is_printable(head)) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = lin_addr(row_q, col_q);
                                wr_data_d = head;
                                if (col_q == COL_LAST) begin
                                    col_d = '0;
                                    row_d = row_next;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // A byte is lost only when the FIFO is full and nothing leaves it this cycle.
    assign ovf_d = ovf_q | (bus.data_ready && fifo_full && !pop);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
    assign bus.busy       = (state_q == CLEAR);
    assign bus.overflow   = ovf_q;

endmodule
